// File: rtl/multicycle_control.sv
// Multicycle controller: Moore FSM that drives the datapath muxes, the
// write enables and the ALU operation for lw, sw, R-type, beq, addi and j.
module multicycle_control #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             opcode,
   input  logic [5:0]             funct,
   input  logic                   zero,
   input  logic                   mem_ready,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   i_or_d,
   output logic                   ir_write,
   output logic                   reg_write,
   output logic                   reg_dst,
   output logic                   mem_to_reg,
   output logic                   alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [2:0]             alu_control,
   output logic [1:0]             pc_source,
   output logic                   pc_en,
   output logic                   illegal_op,
   output logic [COUNT_WIDTH-1:0] instr_count,
   output logic [3:0]             state
);

   localparam logic [3:0] FETCH  = 4'd0;
   localparam logic [3:0] DECODE = 4'd1;
   localparam logic [3:0] MEMADR = 4'd2;
   localparam logic [3:0] MEMRD  = 4'd3;
   localparam logic [3:0] MEMWB  = 4'd4;
   localparam logic [3:0] MEMWR  = 4'd5;
   localparam logic [3:0] EXEC   = 4'd6;
   localparam logic [3:0] ALUWB  = 4'd7;
   localparam logic [3:0] BRANCH = 4'd8;
   localparam logic [3:0] ADDIEX = 4'd9;
   localparam logic [3:0] ADDIWB = 4'd10;
   localparam logic [3:0] JUMP   = 4'd11;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0]             state_q;
   logic [3:0]             state_d;
   logic [3:0]             decode_target;
   logic                   op_legal;
   logic [1:0]             alu_op;
   logic                   pc_write;
   logic                   pc_write_cond;
   logic                   ir_write_raw;
   logic                   mem_write_raw;
   logic                   reg_write_raw;
   logic                   illegal_raw;
   logic                   retire;
   logic [COUNT_WIDTH-1:0] count_q;

   // Opcode dispatch target out of DECODE; unknown opcodes are flagged.
   always_comb begin
      decode_target = FETCH;
      op_legal      = 1'b1;
      case (opcode)
         OP_LW:   decode_target = MEMADR;
         OP_SW:   decode_target = MEMADR;
         OP_RTYP: decode_target = EXEC;
         OP_BEQ:  decode_target = BRANCH;
         OP_ADDI: decode_target = ADDIEX;
         OP_J:    decode_target = JUMP;
         default: begin
            decode_target = FETCH;
            op_legal      = 1'b0;
         end
      endcase
   end

   // Next-state selection; memory states hold until the access completes.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH: begin
            if (mem_ready) state_d = DECODE;
            else           state_d = FETCH;
         end
         DECODE: state_d = decode_target;
         MEMADR: begin
            if (opcode == OP_SW) state_d = MEMWR;
            else                 state_d = MEMRD;
         end
         MEMRD: begin
            if (mem_ready) state_d = MEMWB;
            else           state_d = MEMRD;
         end
         MEMWB: state_d = FETCH;
         MEMWR: begin
            if (mem_ready) state_d = FETCH;
            else           state_d = MEMWR;
         end
         EXEC:   state_d = ALUWB;
         ALUWB:  state_d = FETCH;
         BRANCH: state_d = FETCH;
         ADDIEX: state_d = ADDIWB;
         ADDIWB: state_d = FETCH;
         JUMP:   state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // Instruction completes on the final transition back into FETCH.
   always_comb begin
      retire = 1'b0;
      case (state_q)
         MEMWB:  retire = 1'b1;
         MEMWR:  retire = mem_ready;
         ALUWB:  retire = 1'b1;
         BRANCH: retire = 1'b1;
         ADDIWB: retire = 1'b1;
         JUMP:   retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   // State register, forced back to FETCH by reset at any time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Retired-instruction counter, wraps naturally at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       count_q <= '0;
      else if (retire) count_q <= count_q + COUNT_WIDTH'(1);
   end

   // Per-state datapath controls; anything not set stays at 0.
   always_comb begin
      mem_read      = 1'b0;
      mem_write_raw = 1'b0;
      i_or_d        = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      illegal_raw   = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read     = 1'b1;
            alu_src_b    = 2'b01;
            ir_write_raw = mem_ready;
            pc_write     = mem_ready;
         end
         DECODE: begin
            alu_src_b   = 2'b11;
            illegal_raw = ~op_legal;
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         MEMWB: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = 1'b1;
         end
         MEMWR: begin
            mem_write_raw = 1'b1;
            i_or_d        = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         ALUWB: begin
            reg_write_raw = 1'b1;
            reg_dst       = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ADDIWB: begin
            reg_write_raw = 1'b1;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         default: begin
            mem_read = 1'b0;
         end
      endcase
   end

   // ALU operation: fixed add/sub, or decoded from funct for R-type.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         2'b00: alu_control = ALU_ADD;
         2'b01: alu_control = ALU_SUB;
         2'b10: begin
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

   // Write-type strobes are suppressed for as long as reset is held.
   assign ir_write    = ir_write_raw & ~reset;
   assign mem_write   = mem_write_raw & ~reset;
   assign reg_write   = reg_write_raw & ~reset;
   assign illegal_op  = illegal_raw & ~reset;
   assign pc_en       = (pc_write | (pc_write_cond & zero)) & ~reset;
   assign instr_count = count_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model
// predicts each instruction's effects, a monitor scores them on retirement.
module tb_multicycle_control;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        mem_read, mem_write, i_or_d, ir_write, reg_write;
   logic        reg_dst, mem_to_reg, alu_src_a, pc_en, illegal_op;
   logic [1:0]  alu_src_b, pc_source;
   logic [2:0]  alu_control;
   logic [15:0] instr_count;
   logic [3:0]  state;

   logic        mem_read2, mem_write2, i_or_d2, ir_write2, reg_write2;
   logic        reg_dst2, mem_to_reg2, alu_src_a2, pc_en2, illegal_op2;
   logic [1:0]  alu_src_b2, pc_source2;
   logic [2:0]  alu_control2;
   logic [1:0]  instr_count2;
   logic [3:0]  state2;

   int checks = 0;
   int errors = 0;

   multicycle_control #(.COUNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read),
      .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .pc_source(pc_source), .pc_en(pc_en),
      .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
   );

   multicycle_control #(.COUNT_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read2),
      .mem_write(mem_write2), .i_or_d(i_or_d2), .ir_write(ir_write2),
      .reg_write(reg_write2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
      .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
      .alu_control(alu_control2), .pc_source(pc_source2), .pc_en(pc_en2),
      .illegal_op(illegal_op2), .instr_count(instr_count2), .state(state2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cycles;
      int          rw;
      int          mw;
      int          mr;
      int          iod;
      int          pce;
      int          ill;
      int          irw;
      bit          chk_alu;
      logic [2:0]  alu;
      logic        dst;
      logic        m2r;
      logic [1:0]  psrc;
      logic [15:0] visited;
      logic [15:0] count;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] model_count;
   bit          mon_en = 0;

   // monitor accumulators for the instruction in flight
   int          a_cyc, a_rw, a_mw, a_mr, a_iod, a_pce, a_ill, a_irw;
   logic [2:0]  a_alu;
   logic        a_dst, a_m2r;
   logic [1:0]  a_psrc;
   logic [15:0] a_vis;
   logic [3:0]  prev_state;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
             op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
   endfunction

   task automatic clear_acc();
      a_cyc = 0; a_rw = 0; a_mw = 0; a_mr = 0; a_iod = 0;
      a_pce = 0; a_ill = 0; a_irw = 0;
      a_alu = 3'b000; a_dst = 1'b0; a_m2r = 1'b0; a_psrc = 2'b00;
      a_vis = 16'h0;
   endtask

   // Per-cycle observer: constant FETCH outputs plus per-instruction tallies
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_state != 4'd0 && state == 4'd0) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("cycles", a_cyc, e.cycles);
               chk("reg_write_cycles", a_rw, e.rw);
               chk("mem_write_cycles", a_mw, e.mw);
               chk("mem_read_cycles", a_mr, e.mr);
               chk("i_or_d_cycles", a_iod, e.iod);
               chk("pc_en_cycles", a_pce, e.pce);
               chk("illegal_pulses", a_ill, e.ill);
               chk("ir_write_cycles", a_irw, e.irw);
               chk("states_visited", a_vis, e.visited);
               chk("wb_reg_dst", a_dst, e.dst);
               chk("wb_mem_to_reg", a_m2r, e.m2r);
               chk("pc_source", a_psrc, e.psrc);
               if (e.chk_alu) chk("exec_alu_control", a_alu, e.alu);
               chk("instr_count", instr_count, e.count);
               chk("instr_count_w2", instr_count2, e.count[1:0]);
            end
            clear_acc();
         end
         if (state == 4'd0) begin
            chk("fetch_outputs",
                {mem_read, i_or_d, alu_src_a, alu_src_b, alu_control,
                 pc_source, reg_write, mem_write},
                12'b1_0_0_01_010_00_0_0);
            chk("fetch_strobes", {ir_write, pc_en}, {2{mem_ready}});
         end
         a_cyc++;
         a_vis[state] = 1'b1;
         if (reg_write) begin
            a_rw++;
            a_dst = reg_dst;
            a_m2r = mem_to_reg;
         end
         if (mem_write)  a_mw++;
         if (mem_read)   a_mr++;
         if (i_or_d)     a_iod++;
         if (ir_write)   a_irw++;
         if (illegal_op) a_ill++;
         if (pc_en) begin
            a_pce++;
            a_psrc = pc_source;
         end
         if (state == 4'd6) a_alu = alu_control;
         prev_state = state;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // cls: 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 j, 6 illegal
   task automatic run_instr(input int cls, input int fw, input int mw,
                            input logic [5:0] fn, input logic z);
      exp_t       e;
      logic [5:0] op;
      int         base;
      bit         mem;
      logic [5:0] fl[7];
      int         n;
      fl[0] = 6'd0; fl[1] = 6'd0; fl[2] = 6'd0; fl[3] = 6'd0;
      fl[4] = 6'd0; fl[5] = 6'd0; fl[6] = 6'd0;
      case (cls)
         0: begin op = 6'b100011; base = 5; end
         1: begin op = 6'b101011; base = 4; end
         2: begin op = 6'b000000; base = 4; end
         3: begin op = 6'b000100; base = 3; end
         4: begin op = 6'b001000; base = 4; end
         5: begin op = 6'b000010; base = 3; end
         default: begin
            op = 6'($urandom);
            while (is_legal(op)) op = 6'($urandom);
            base = 2;
         end
      endcase
      mem = (cls == 0 || cls == 1);
      if (!mem) mw = 0;
      if (cls != 6) model_count = model_count + 16'd1;
      e.cycles  = base + fw + mw;
      e.rw      = (cls == 0 || cls == 2 || cls == 4) ? 1 : 0;
      e.mw      = (cls == 1) ? mw + 1 : 0;
      e.mr      = fw + 1 + ((cls == 0) ? mw + 1 : 0);
      e.iod     = mem ? mw + 1 : 0;
      e.pce     = 1 + ((cls == 5) ? 1 : 0) + ((cls == 3 && z) ? 1 : 0);
      e.ill     = (cls == 6) ? 1 : 0;
      e.irw     = 1;
      e.chk_alu = (cls == 2);
      e.alu     = alu_of(fn);
      e.dst     = (cls == 2);
      e.m2r     = (cls == 0);
      e.psrc    = (cls == 5) ? 2'b10 : (cls == 3 && z) ? 2'b01 : 2'b00;
      case (cls)
         0: e.visited = 16'b0000_0000_0001_1111;
         1: e.visited = 16'b0000_0000_0010_0111;
         2: e.visited = 16'b0000_0000_1100_0011;
         3: e.visited = 16'b0000_0001_0000_0011;
         4: e.visited = 16'b0000_0110_0000_0011;
         5: e.visited = 16'b0000_1000_0000_0011;
         default: e.visited = 16'b0000_0000_0000_0011;
      endcase
      e.count = model_count;
      sb_q.push_back(e);
      opcode = op;
      funct  = fn;
      zero   = z;
      for (int i = 0; i < fw; i++) begin
         mem_ready = 1'b0;
         step();
      end
      mem_ready = 1'b1;
      step();
      n = base - 1 + mw;
      for (int k = 0; k < n; k++) begin
         if (mem && k >= 2 && k < 2 + mw) mem_ready = 1'b0;
         else if (mem && k == 2 + mw)     mem_ready = 1'b1;
         else                             mem_ready = 1'($urandom);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] fns[6];
      fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
      fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b110011;
      reset = 1'b0; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0;
      zero = 1'b0; model_count = 16'd0;
      #1 reset = 1'b1;
      step(); step();
      @(negedge clk);
      chk("reset_state", state, 4'd0);
      chk("reset_count", instr_count, 16'd0);
      chk("reset_strobes",
          {ir_write, pc_en, mem_write, reg_write, illegal_op}, 5'b0);
      chk("reset_outputs",
          {mem_read, i_or_d, alu_src_a, alu_src_b, alu_control, pc_source},
          10'b1_0_0_01_010_00);
      @(posedge clk);
      #1 reset = 1'b0;
      clear_acc();
      prev_state = 4'd0;
      mon_en = 1'b1;
      run_instr(0, 0, 0, 6'b100000, 1'b0);
      run_instr(1, 0, 3, 6'b100000, 1'b0);
      run_instr(2, 0, 0, 6'b100010, 1'b0);
      run_instr(2, 1, 0, 6'b101010, 1'b1);
      run_instr(2, 0, 0, 6'b100101, 1'b0);
      run_instr(3, 0, 0, 6'b000000, 1'b1);
      run_instr(3, 0, 0, 6'b000000, 1'b0);
      run_instr(6, 0, 0, 6'b000000, 1'b0);
      for (int t = 0; t < 80; t++) begin
         run_instr($urandom_range(0, 6), $urandom_range(0, 2),
                   $urandom_range(0, 3), fns[$urandom_range(0, 5)],
                   1'($urandom));
      end
      mem_ready = 1'b0;
      step(); step();
      chk("scoreboard_drained", sb_q.size(), 0);
      mon_en = 1'b0;

      opcode = 6'b100011;
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (state == 4'd3) break;
         step();
      end
      chk("reach_memrd", state, 4'd3);
      mem_ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("async_reset_state", state, 4'd0);
      chk("async_reset_count", instr_count, 16'd0);
      chk("async_reset_count_w2", instr_count2, 2'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      chk("reset_held_strobes",
          {ir_write, pc_en, mem_write, reg_write, illegal_op}, 5'b0);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("release_state", state, 4'd0);
      chk("release_strobes",
          {ir_write, pc_en, mem_write, reg_write, illegal_op}, 5'b0);
      @(posedge clk);
      #1;
      chk("release_hold_fetch", state, 4'd0);
      opcode = 6'b000010;
      mem_ready = 1'b1;
      for (int i = 0; i < 15; i++) step();
      chk("five_jumps_state", state, 4'd0);
      chk("five_jumps_count", instr_count, 16'd5);
      chk("five_jumps_wrap_w2", instr_count2, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
